float_mult_seq: RTL

- Parametrised, handshaked successor to the fixed 24-bit float multiplier datapath (sign / exponent / mantissa pipeline with overflow/underflow flags).
- Multiplies two floats of configurable width using an iterative shift-add mantissa multiplier controlled by an FSM.
- Adds zero handling, optional round-to-nearest-even, saturation on overflow and flush-to-zero on underflow.
- Sits between an operand source and a result consumer, using valid/ready on both sides.

---
 rtl/float_pkg.sv | 48 ++++
 rtl/float_round_norm.sv | 93 +++++++++
 rtl/float_mult_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float format helpers, FSM states and constant builders
//
// Float words are laid out {sign, exp, mant}. An exp field of 0 means zero.
// Every other exp code is a normal number with an implicit leading 1.
// There are no denormals, infinities or NaNs.
package float_pkg;

    localparam int EXP_W_DEF = 7;
    localparam int MAN_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int float_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int float_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Bit index of the sign bit.
    function automatic int sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    // Bit index of the exponent LSB; the mantissa occupies [exp_lsb-1:0].
    function automatic int exp_lsb(input int man_w);
        return man_w;
    endfunction

    // Saturated word: all-ones exponent and mantissa, with the given sign.
    // The result is 64 bits wide; callers keep the low float_width bits.
    function automatic logic [63:0] float_sat_word(input logic s, input int exp_w, input int man_w);
        return (64'(s) << (exp_w + man_w)) | ((64'd1 << (exp_w + man_w)) - 64'd1);
    endfunction

    // Signed zero: sign bit only.
    function automatic logic [63:0] float_zero_word(input logic s, input int exp_w, input int man_w);
        return 64'(s) << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/float_round_norm.sv
// rtl/float_round_norm.sv - combinational normalise, round and range check for a raw mantissa product
//
// Ports:
//   sign        in   result sign
//   prod        in   raw product of two (1+MAN_W)-bit mantissas, 2*MAN_W+2 bits
//   exp_in      in   signed exponent that goes with prod, EXP_W+2 bits
//   sticky_in   in   bits already discarded below prod
//   norm_prod   out  prod shifted right by 1 when its top bit is set
//   norm_exp    out  exp_in, plus 1 when a shift happened
//   norm_sticky out  sticky_in, ORed with any bit the shift dropped
//   result      out  rounded and range-checked word {sign, exp, mant}
//                    (expects prod and exp_in already normalised)
//   overflow    out  result saturated
//   underflow   out  result flushed to zero
module float_round_norm #(
    parameter int EXP_W    = 7,
    parameter int MAN_W    = 16,
    parameter int ROUND_EN = 1
) (
    input  logic                    sign,
    input  logic [2*MAN_W+1:0]      prod,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic                    sticky_in,
    output logic [2*MAN_W+1:0]      norm_prod,
    output logic signed [EXP_W+1:0] norm_exp,
    output logic                    norm_sticky,
    output logic [EXP_W+MAN_W:0]    result,
    output logic                    overflow,
    output logic                    underflow
);
    import float_pkg::*;

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [63:0] SAT_POS  = float_sat_word(1'b0, EXP_W, MAN_W);
    localparam logic [63:0] SAT_NEG  = float_sat_word(1'b1, EXP_W, MAN_W);
    localparam logic [63:0] ZERO_POS = float_zero_word(1'b0, EXP_W, MAN_W);
    localparam logic [63:0] ZERO_NEG = float_zero_word(1'b1, EXP_W, MAN_W);
    localparam logic signed [EXP_W+1:0] ONE = (EXP_W+2)'(1);

    logic [MAN_W-1:0]        mant;
    logic [MAN_W-1:0]        mant_r;
    logic [MAN_W:0]          mant_inc;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic signed [EXP_W+1:0] exp_r;

    // The product of two values in [1,2) lies in [1,4).
    // If it reached 2, move the binary point one place left.
    always_comb begin
        norm_prod   = prod;
        norm_exp    = exp_in;
        norm_sticky = sticky_in;
        if (prod[2*MAN_W+1]) begin
            norm_prod   = prod >> 1;
            norm_exp    = exp_in + ONE;
            norm_sticky = sticky_in | prod[0];
        end
    end

    always_comb begin
        mant     = prod[2*MAN_W-1:MAN_W];
        guard    = prod[MAN_W-1];
        sticky   = (|prod[MAN_W-2:0]) | sticky_in;
        round_up = (ROUND_EN != 0) && guard && (sticky || mant[0]);
        mant_inc = {1'b0, mant} + (MAN_W+1)'(1);
        mant_r   = mant;
        exp_r    = exp_in;
        if (round_up) begin
            if (mant_inc[MAN_W]) begin
                // 1.111..1 rounded up becomes 10.000..0, so bump the exponent.
                mant_r = '0;
                exp_r  = exp_in + ONE;
            end else begin
                mant_r = mant_inc[MAN_W-1:0];
            end
        end

        // exp_r never reaches 2^(EXP_W+1).
        // So a non-negative value with bit EXP_W set is >= 2^EXP_W.
        overflow  = !exp_r[EXP_W+1] && exp_r[EXP_W];
        underflow = exp_r[EXP_W+1] || (exp_r == '0);

        if (overflow) begin
            result = sign ? SAT_NEG[W-1:0] : SAT_POS[W-1:0];
        end else if (underflow) begin
            result = sign ? ZERO_NEG[W-1:0] : ZERO_POS[W-1:0];
        end else begin
            result = {sign, exp_r[EXP_W-1:0], mant_r};
        end
    end

endmodule

// File: rtl/float_mult_seq.sv
// rtl/float_mult_seq.sv - handshaked iterative float multiplier (shift-add mantissa, FSM controlled)
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous active-low reset
//   in_valid/in_ready   in/out  operand handshake; in_ready is high only in IDLE
//   float_a, float_b    in   operands {sign, exp, mant}
//   out_valid/out_ready out/in  result handshake; out_valid is high only in DONE
//   float_out           out  product, held stable while out_valid is high
//   float_out_overflow  out  result saturated
//   float_out_underflow out  result flushed to zero
module float_mult_seq #(
    parameter int EXP_W    = 7,
    parameter int MAN_W    = 16,
    parameter int ROUND_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] float_a,
    input  logic [EXP_W+MAN_W:0] float_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] float_out,
    output logic                 float_out_overflow,
    output logic                 float_out_underflow
);
    import float_pkg::*;

    localparam int W        = float_width(EXP_W, MAN_W);
    localparam int PW       = 2*MAN_W + 2;
    localparam int SIGN_POS = sign_pos(EXP_W, MAN_W);
    localparam int EXP_LSB  = exp_lsb(MAN_W);
    localparam int CNT_W    = $clog2(MAN_W + 1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(MAN_W);
    localparam logic [EXP_W+1:0]   BIAS_V = (EXP_W+2)'(float_bias(EXP_W));
    localparam logic [63:0] ZERO_POS = float_zero_word(1'b0, EXP_W, MAN_W);
    localparam logic [63:0] ZERO_NEG = float_zero_word(1'b1, EXP_W, MAN_W);

    state_t state, state_next;

    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        ma, mb;
    logic                    sign_in;
    logic                    zero_in;
    logic                    accept;
    logic signed [EXP_W+1:0] exp_sum;

    logic                    sign_r;
    logic signed [EXP_W+1:0] exp_r;
    logic                    sticky_r;
    logic [PW-1:0]           acc;
    logic [PW-1:0]           mcand;
    logic [MAN_W:0]          mplier;
    logic [CNT_W-1:0]        count;

    logic [PW-1:0]           norm_prod;
    logic signed [EXP_W+1:0] norm_exp;
    logic                    norm_sticky;
    logic [W-1:0]            rn_result;
    logic                    rn_overflow;
    logic                    rn_underflow;

    assign ea      = float_a[SIGN_POS-1:EXP_LSB];
    assign eb      = float_b[SIGN_POS-1:EXP_LSB];
    assign ma      = float_a[EXP_LSB-1:0];
    assign mb      = float_b[EXP_LSB-1:0];
    assign sign_in = float_a[SIGN_POS] ^ float_b[SIGN_POS];
    assign zero_in = (ea == '0) || (eb == '0);
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS_V;
    assign accept  = in_valid && in_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = zero_in ? S_DONE : S_MUL;
            S_MUL:   if (count == LAST) state_next = S_NORM;
            S_NORM:  state_next = S_ROUND;
            S_ROUND: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: handshake outputs, decoded from the registered state only
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_r              <= 1'b0;
            exp_r               <= '0;
            sticky_r            <= 1'b0;
            acc                 <= '0;
            mcand               <= '0;
            mplier              <= '0;
            count               <= '0;
            float_out           <= '0;
            float_out_overflow  <= 1'b0;
            float_out_underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_r   <= sign_in;
                        exp_r    <= exp_sum;
                        sticky_r <= 1'b0;
                        acc      <= '0;
                        count    <= '0;
                        mcand    <= {{(MAN_W+1){1'b0}}, 1'b1, ma};
                        mplier   <= {1'b1, mb};
                        if (zero_in) begin
                            float_out <= sign_in ? ZERO_NEG[W-1:0] : ZERO_POS[W-1:0];
                        end
                    end
                end
                S_MUL: begin
                    // Multiplier LSB first.
                    // The multiplicand shifts up to stay aligned with it.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                end
                S_NORM: begin
                    acc      <= norm_prod;
                    exp_r    <= norm_exp;
                    sticky_r <= norm_sticky;
                end
                S_ROUND: begin
                    float_out           <= rn_result;
                    float_out_overflow  <= rn_overflow;
                    float_out_underflow <= rn_underflow;
                end
                S_DONE: begin
                    if (out_ready) begin
                        float_out           <= '0;
                        float_out_overflow  <= 1'b0;
                        float_out_underflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    float_round_norm #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_EN (ROUND_EN)
    ) u_round_norm (
        .sign        (sign_r),
        .prod        (acc),
        .exp_in      (exp_r),
        .sticky_in   (sticky_r),
        .norm_prod   (norm_prod),
        .norm_exp    (norm_exp),
        .norm_sticky (norm_sticky),
        .result      (rn_result),
        .overflow    (rn_overflow),
        .underflow   (rn_underflow)
    );

endmodule
